alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Sequential execute unit downstream of the ALU control decoder: it consumes the 3-bit ALU control code plus two operands and produces a registered result and zero flag. Single-cycle ops (add, sub, xor, or, and) finish in one cycle. Shifts run iteratively, one bit per cycle, unless the fast-shift option is compiled in. Start/done handshake lets the surrounding datapath stall while the unit is busy.

## Interface
- WIDTH, 32: operand/result width; must be a power of two ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  in  1  request; accepted only when ready=1.
- alu_ctrl  in  3  ALU control code from the decoder.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B; shifts use src_b[SHW-1:0] as the amount.
- ready  out  1  high when idle and able to accept.
- done  out  1  one-cycle pulse when result/zero are updated.
- result  out  WIDTH  registered result; holds until the next done.
- zero  out  1  registered, equals (result == 0); updates with result.

## Operation
- Codes: 000 add, 010 sub (a−b), 001 sll, 101 srl (logical), 100 xor, 110 or, 111 and, 011 treated as add.
- All arithmetic is modulo 2^WIDTH; carry and overflow are discarded.
- States are IDLE, SHIFT, and DONE.
- IDLE: ready=1. When start=1, operands, code, and shift count are latched.
  - Non-shift op or shift count 0: go to DONE.
  - Shift op with count>0: go to SHIFT.
- SHIFT: ready=0. Each cycle the working register shifts one bit in the direction of the code and the count decrements. When the count reaches 0 after the decrement, go to DONE.
- DONE: writes result and zero, pulses done=1, and returns to IDLE. ready=0 in DONE.
- start while ready=0 is ignored; inputs need not be held after acceptance.
- Reset at any point, including mid-shift:
  - state goes to IDLE;
  - result is 0, zero is 1, done is 0, ready is 1;
  - the shift count is cleared.

## Timing
- Reset values: ready=1, done=0, result=0, zero=1.
- Start is accepted at edge N.
  - Non-shift op: done=1 during cycle N+1 and result is valid from N+1. ready returns at N+2.
  - Shift by k>0 (iterative): done during cycle N+1+k.
  - Shift by WIDTH−1: done during cycle N+WIDTH.
- Back-to-back issue interval is 2 cycles for non-shift ops.
- done and ready are never high in the same cycle.

## Configuration
- Macro ALU_SEQ_FAST_SHIFT_EN.
  - Defined: shifts use a combinational barrel shift and take the non-shift path. Latency is 1 for every op and the SHIFT state is unreachable.
  - Undefined: iterative one-bit-per-cycle shifting as above.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package alu_seq_pkg:
  - localparams for the seven ALU control codes;
  - state enum {IDLE, SHIFT, DONE};
  - default WIDTH.
- The decoder must import the same code constants.
- One sub-module, alu_seq_shift_step: combinational single-bit left/right logical shift of a WIDTH-bit word. It is instantiated once in the iterative build and unused in the fast build.

## Test plan
- Reset then add: rst_n low for 2 cycles, then start with ctrl=000, a=5, b=7. Expect done at N+1, result=12, zero=0, ready=1 at N+2.
- Sub to zero and wrap: ctrl=010 with a=9, b=9 gives result=0, zero=1. Then a=0, b=1 gives result=0xFFFFFFFF.
- Iterative shifts:
  - sll with a=1, b=31 gives done at N+32 and result=0x80000000.
  - srl with a=0x80000000, b=4 gives done at N+5 and result=0x08000000.
  - b=32 uses amount 0: done at N+1 and result=a.
- Busy rejection: a start pulse with new operands during SHIFT is ignored. Only the original result appears, and a single done pulse occurs.
- Mid-shift reset: rst_n low during SHIFT. Next cycle ready=1, result=0, zero=1, done=0, and no late done follows.
- Fast build (ALU_SEQ_FAST_SHIFT_EN): sll with a=3, b=30 gives done at N+1 and result=0xC0000000.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU execute unit: control codes, FSM states, default width.
// Consumed by alu_seq_if, alu_seq_shift_step and alu_seq_unit.
package alu_seq_pkg;

   localparam int unsigned DefWidth = 32;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSll = 3'b001;
   localparam logic [2:0] AluSub = 3'b010;
   localparam logic [2:0] AluXor = 3'b100;
   localparam logic [2:0] AluSrl = 3'b101;
   localparam logic [2:0] AluOr  = 3'b110;
   localparam logic [2:0] AluAnd = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   function automatic logic is_shift_op(input logic [2:0] ctrl);
      return (ctrl == AluSll) || (ctrl == AluSrl);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Start/done request bus between the datapath (master) and the sequential ALU (slave).
interface alu_seq_if #(
   parameter int unsigned WIDTH = alu_seq_pkg::DefWidth
) ();

   logic             start;
   logic [2:0]       alu_ctrl;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (
      output start, alu_ctrl, src_a, src_b,
      input  ready, done, result, zero
   );

   modport slave (
      input  start, alu_ctrl, src_a, src_b,
      output ready, done, result, zero
   );

endinterface

// File: rtl/alu_seq_shift_step.sv
// Combinational single-bit logical shift of a WIDTH-bit word, left or right.
module alu_seq_shift_step #(
   parameter int unsigned WIDTH = alu_seq_pkg::DefWidth
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_left,
   output logic [WIDTH-1:0] o_data
);

   assign o_data = i_left ? {i_data[WIDTH-2:0], 1'b0} : {1'b0, i_data[WIDTH-1:1]};

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU execute unit: single-cycle logic/arith ops, iterative shifts by default.
// Define ALU_SEQ_FAST_SHIFT_EN to replace iterative shifting with a one-cycle barrel shift.
module alu_seq_unit
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   alu_seq_if.slave  io_bus
);

   localparam int unsigned SHW = $clog2(WIDTH);

   state_e           r_state;
   state_e           w_state_next;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_work;
   logic [SHW-1:0]   r_count;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;

   logic [SHW-1:0]   w_amt;
   logic             w_accept;
   logic             w_go_shift;
   logic [WIDTH-1:0] w_alu_y;
   logic [WIDTH-1:0] w_step;
   logic [WIDTH-1:0] w_result_next;
   logic             w_load_result;

   assign w_amt    = io_bus.src_b[SHW-1:0];
   assign w_accept = (r_state == StIdle) && io_bus.start;

`ifdef ALU_SEQ_FAST_SHIFT_EN
   assign w_go_shift = 1'b0;
   assign w_step     = r_work;
`else
   assign w_go_shift = is_shift_op(io_bus.alu_ctrl) && (w_amt != '0);

   alu_seq_shift_step #(
      .WIDTH (WIDTH)
   ) u_shift_step (
      .i_data (r_work),
      .i_left (r_op == AluSll),
      .o_data (w_step)
   );
`endif

   // Single-cycle result; code 011 falls through to add.
   always_comb begin
      w_alu_y = io_bus.src_a + io_bus.src_b;
      case (io_bus.alu_ctrl)
         AluSub: w_alu_y = io_bus.src_a - io_bus.src_b;
         AluXor: w_alu_y = io_bus.src_a ^ io_bus.src_b;
         AluOr:  w_alu_y = io_bus.src_a | io_bus.src_b;
         AluAnd: w_alu_y = io_bus.src_a & io_bus.src_b;
`ifdef ALU_SEQ_FAST_SHIFT_EN
         AluSll: w_alu_y = io_bus.src_a << w_amt;
         AluSrl: w_alu_y = io_bus.src_a >> w_amt;
`else
         AluSll, AluSrl: w_alu_y = io_bus.src_a;
`endif
         default: w_alu_y = io_bus.src_a + io_bus.src_b;
      endcase
   end

   always_comb begin
      w_state_next  = r_state;
      w_load_result = 1'b0;
      w_result_next = w_alu_y;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               if (w_go_shift) begin
                  w_state_next = StShift;
               end else begin
                  w_state_next  = StDone;
                  w_load_result = 1'b1;
               end
            end
         end
         StShift: begin
            // Count of 1 means this step is the last one.
            if (r_count == SHW'(1)) begin
               w_state_next  = StDone;
               w_load_result = 1'b1;
               w_result_next = w_step;
            end
         end
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_op     <= AluAdd;
         r_work   <= '0;
         r_count  <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op    <= io_bus.alu_ctrl;
            r_work  <= io_bus.src_a;
            r_count <= w_amt;
         end else if (r_state == StShift) begin
            r_work  <= w_step;
            r_count <= r_count - SHW'(1);
         end
         if (w_load_result) begin
            r_result <= w_result_next;
            r_zero   <= (w_result_next == '0);
         end
      end
   end

   assign io_bus.ready  = (r_state == StIdle);
   assign io_bus.done   = (r_state == StDone);
   assign io_bus.result = r_result;
   assign io_bus.zero   = r_zero;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases plus random ops against an arithmetic model.
module tb_alu_seq_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_seq_if #(.WIDTH(32)) bus ();

   alu_seq_unit #(
      .WIDTH (32)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (c)
         3'd1:    return a << sh;
         3'd2:    return a - b;
         3'd4:    return a ^ b;
         3'd5:    return a >> sh;
         3'd6:    return a | b;
         3'd7:    return a & b;
         default: return a + b;
      endcase
   endfunction

   // Extra cycles beyond the single-cycle path.
   function automatic int ref_lat(input logic [2:0] c, input logic [31:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
      return 0;
`else
      if (c == 3'd1 || c == 3'd5) return int'(b % 32);
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
      int          lat;
      int          cyc;
      bit          rdy_seen;
      logic [31:0] exp;
      exp = ref_alu(c, a, b);
      lat = ref_lat(c, b);
      chk({tag, " ready_before"}, 32'(bus.ready), 32'd1);
      bus.start    = 1'b1;
      bus.alu_ctrl = c;
      bus.src_a    = a;
      bus.src_b    = b;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.src_a    = $urandom;
      bus.src_b    = $urandom;
      bus.alu_ctrl = 3'($urandom);
      cyc          = 0;
      rdy_seen     = 1'b0;
      while (bus.done !== 1'b1 && cyc < 80) begin
         if (bus.ready !== 1'b0) rdy_seen = 1'b1;
         bus.start = (poke && cyc == 1);
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0;
      chk({tag, " latency"}, 32'(cyc), 32'(lat));
      chk({tag, " ready_while_busy"}, 32'(rdy_seen), 32'd0);
      chk({tag, " ready_with_done"}, 32'(bus.ready), 32'd0);
      chk({tag, " result"}, bus.result, exp);
      chk({tag, " zero"}, 32'(bus.zero), 32'(exp == 32'd0));
      @(posedge clk); #1;
      chk({tag, " done_after"}, 32'(bus.done), 32'd0);
      chk({tag, " ready_after"}, 32'(bus.ready), 32'd1);
      if (poke) begin
         @(posedge clk); #1;
         chk({tag, " single_done"}, 32'(bus.done), 32'd0);
         chk({tag, " result_kept"}, bus.result, exp);
      end
   endtask

   initial begin
      int ndone;
      logic [2:0]  rc;
      logic [31:0] ra;
      logic [31:0] rb;
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.alu_ctrl = 3'd0;
      bus.src_a    = '0;
      bus.src_b    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset ready", 32'(bus.ready), 32'd1);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset result", bus.result, 32'd0);
      chk("reset zero", 32'(bus.zero), 32'd1);
      rst_n = 1'b1;

      do_op("add", 3'd0, 32'd5, 32'd7, 1'b0);
      do_op("sub_zero", 3'd2, 32'd9, 32'd9, 1'b0);
      do_op("sub_wrap", 3'd2, 32'd0, 32'd1, 1'b0);
      do_op("sll31", 3'd1, 32'd1, 32'd31, 1'b0);
      do_op("srl4", 3'd5, 32'h8000_0000, 32'd4, 1'b0);
      do_op("sll_amt32", 3'd1, 32'h1234_5678, 32'd32, 1'b0);
      do_op("sll30", 3'd1, 32'd3, 32'd30, 1'b0);
      do_op("code011", 3'd3, 32'hFFFF_FFFF, 32'd2, 1'b0);
      do_op("busy_reject", 3'd5, 32'hF0F0_0000, 32'd12, 1'b1);

      // Reset in the middle of a shift must abort it without a late done.
      bus.start    = 1'b1;
      bus.alu_ctrl = 3'd1;
      bus.src_a    = 32'd1;
      bus.src_b    = 32'd20;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst ready", 32'(bus.ready), 32'd1);
      chk("midrst result", bus.result, 32'd0);
      chk("midrst zero", 32'(bus.zero), 32'd1);
      chk("midrst done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      ndone = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) ndone++;
      end
      chk("midrst no_late_done", 32'(ndone), 32'd0);
      chk("midrst ready_idle", 32'(bus.ready), 32'd1);

      for (int i = 0; i < 24; i++) begin
         rc = 3'($urandom);
         ra = $urandom;
         rb = (i % 4 == 0) ? 32'd0 : $urandom;
         if (i % 5 == 0) rb = ra;
         do_op("random", rc, ra, rb, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
